sprite_path_mover: RTL and testbench

- Parametrised successor to the single-step sprite move FSM for the 320x240 VGA game.
- Holds the character's (x, y) position and a runtime-loadable table of walkable diagonal path segments.
- On each move request it computes the target position and checks it against screen bounds and the segment table, scanning one segment per cycle.
- For an accepted move it runs the background-erase / position-update / character-draw handshake with the renderers.

---
 rtl/sprite_path_mover_if.sv | 47 ++++
 rtl/sprite_path_mover.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_path_mover.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_path_mover_if.sv
// Handshake and table-load bundle for sprite_path_mover.
// The master side drives move requests, table writes and renderer acknowledgements.
interface sprite_path_mover_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int C_W     = 10,
  parameter int NUM_SEG = 8
);
  localparam int IDX_W = $clog2(NUM_SEG);

  logic             ld_dir;
  logic [1:0]       dir;
  logic             move;
  logic             set_pos;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic             seg_we;
  logic [IDX_W-1:0] seg_idx;
  logic             seg_en;
  logic             seg_kind;
  logic [C_W-1:0]   seg_c;
  logic [X_W-1:0]   seg_xmin;
  logic [X_W-1:0]   seg_xmax;
  logic             done_bg;
  logic             done_char;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             draw_bg;
  logic             draw_char;
  logic             busy;
  logic             move_ok;
  logic             move_rej;

  modport master (
    output ld_dir, dir, move, set_pos, pos_x, pos_y,
           seg_we, seg_idx, seg_en, seg_kind, seg_c, seg_xmin, seg_xmax,
           done_bg, done_char,
    input  x, y, draw_bg, draw_char, busy, move_ok, move_rej
  );

  modport slave (
    input  ld_dir, dir, move, set_pos, pos_x, pos_y,
           seg_we, seg_idx, seg_en, seg_kind, seg_c, seg_xmin, seg_xmax,
           done_bg, done_char,
    output x, y, draw_bg, draw_char, busy, move_ok, move_rej
  );
endinterface

// File: rtl/sprite_path_mover.sv
// Diagonal sprite mover: bounds check, one-segment-per-cycle walkability scan,
// then the erase / update / draw handshake with the background and character renderers.
module sprite_path_mover #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int C_W     = 10,
  parameter int NUM_SEG = 8,
  parameter int STEP    = 1,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int INIT_X  = 1,
  parameter int INIT_Y  = 16
) (
  input logic                 clock,
  input logic                 resetn,
  sprite_path_mover_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_SEG);
  localparam int XE_W  = X_W + 2;
  localparam int YE_W  = Y_W + 2;
  localparam int EQ_W  = C_W + 1;

  typedef enum logic [3:0] {
    IDLE, ARMED, CALC, SCAN, DRAW_BG, WAIT_BG, UPDATE, DRAW_CHAR, WAIT_CHAR
  } state_t;

  state_t           state_q;
  logic [1:0]       dir_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [X_W:0]     nx_q;
  logic [Y_W:0]     ny_q;
  logic [IDX_W-1:0] idx_q;
  logic             draw_bg_q;
  logic             draw_char_q;
  logic             busy_q;
  logic             ok_q;
  logic             rej_q;

  logic [NUM_SEG-1:0]     seg_en_q;
  logic                   seg_kind_q [NUM_SEG];
  logic signed [C_W-1:0]  seg_c_q    [NUM_SEG];
  logic [X_W-1:0]         seg_xmin_q [NUM_SEG];
  logic [X_W-1:0]         seg_xmax_q [NUM_SEG];

  logic signed [XE_W-1:0] nx_d;
  logic signed [YE_W-1:0] ny_d;
  logic                   calc_oob;
  logic                   scan_hit;

  function automatic logic seg_hit(
    input logic                  en,
    input logic                  kind,
    input logic signed [C_W-1:0] c,
    input logic [X_W-1:0]        xmin,
    input logic [X_W-1:0]        xmax,
    input logic [X_W:0]          nx,
    input logic [Y_W:0]          ny
  );
    logic signed [EQ_W-1:0] xe;
    logic signed [EQ_W-1:0] ye;
    logic signed [EQ_W-1:0] ce;
    logic signed [EQ_W-1:0] lhs;
    xe  = signed'(EQ_W'(nx));
    ye  = signed'(EQ_W'(ny));
    ce  = EQ_W'(c);
    lhs = kind ? (ye - xe) : (xe + ye);
    return en && ({1'b0, xmin} <= nx) && (nx <= {1'b0, xmax}) && (lhs == ce);
  endfunction

  // Two guard bits so a step below zero shows up as a negative value
  always_comb begin
    nx_d = signed'({2'b00, x_q});
    ny_d = signed'({2'b00, y_q});
    if (dir_q[0]) nx_d = nx_d - XE_W'(STEP);
    else          nx_d = nx_d + XE_W'(STEP);
    if (dir_q[1]) ny_d = ny_d - YE_W'(STEP);
    else          ny_d = ny_d + YE_W'(STEP);
    calc_oob = (nx_d <= 0) || (nx_d > XE_W'(X_MAX)) ||
               (ny_d <= 0) || (ny_d > YE_W'(Y_MAX));
  end

  assign scan_hit = seg_hit(seg_en_q[idx_q], seg_kind_q[idx_q], seg_c_q[idx_q],
                            seg_xmin_q[idx_q], seg_xmax_q[idx_q], nx_q, ny_q);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      dir_q       <= 2'd0;
      x_q         <= X_W'(INIT_X);
      y_q         <= Y_W'(INIT_Y);
      idx_q       <= '0;
      draw_bg_q   <= 1'b0;
      draw_char_q <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      draw_bg_q   <= 1'b0;
      draw_char_q <= 1'b0;
      ok_q        <= 1'b0;
      rej_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.set_pos) begin
            x_q <= bus.pos_x;
            y_q <= bus.pos_y;
          end else if (bus.ld_dir) begin
            dir_q   <= bus.dir;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (bus.ld_dir) dir_q <= bus.dir;
          if (bus.move) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          if (calc_oob) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rej_q   <= 1'b1;
          end else begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            state_q   <= DRAW_BG;
            draw_bg_q <= 1'b1;
          end else if (idx_q == IDX_W'(NUM_SEG - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rej_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DRAW_BG: state_q <= WAIT_BG;
        WAIT_BG: if (bus.done_bg) state_q <= UPDATE;
        UPDATE: begin
          x_q         <= nx_q[X_W-1:0];
          y_q         <= ny_q[Y_W-1:0];
          state_q     <= DRAW_CHAR;
          draw_char_q <= 1'b1;
        end
        DRAW_CHAR: state_q <= WAIT_CHAR;
        WAIT_CHAR: begin
          if (bus.done_char) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ok_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Target is captured once in CALC so the scan and update use a stable value
  always_ff @(posedge clock) begin
    if (state_q == CALC) begin
      nx_q <= nx_d[X_W:0];
      ny_q <= ny_d[Y_W:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_en_q <= '0;
    end else if (bus.seg_we && (state_q != SCAN)) begin
      seg_en_q[bus.seg_idx] <= bus.seg_en;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.seg_we && (state_q != SCAN)) begin
      seg_kind_q[bus.seg_idx] <= bus.seg_kind;
      seg_c_q[bus.seg_idx]    <= $signed(bus.seg_c);
      seg_xmin_q[bus.seg_idx] <= bus.seg_xmin;
      seg_xmax_q[bus.seg_idx] <= bus.seg_xmax;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.draw_bg   = draw_bg_q;
  assign bus.draw_char = draw_char_q;
  assign bus.busy      = busy_q;
  assign bus.move_ok   = ok_q;
  assign bus.move_rej  = rej_q;

endmodule

// File: tb/tb_sprite_path_mover.sv
// Bench for sprite_path_mover: directed scenarios then randomized moves, every cycle
// compared against a transaction-level model of position, table and move outcome.
module tb_sprite_path_mover;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int C_W     = 10;
  localparam int NUM_SEG = 8;
  localparam int IDX_W   = $clog2(NUM_SEG);
  localparam int STEP    = 1;
  localparam int X_MAX   = 319;
  localparam int Y_MAX   = 239;
  localparam int INIT_X  = 1;
  localparam int INIT_Y  = 16;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  sprite_path_mover_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .NUM_SEG(NUM_SEG)) bus();

  sprite_path_mover #(
    .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .NUM_SEG(NUM_SEG), .STEP(STEP),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int nbusy;

  int mx, my;
  bit e_busy, e_bg, e_char, e_ok, e_rej;
  bit m_en   [NUM_SEG];
  bit m_kind [NUM_SEG];
  int m_c    [NUM_SEG];
  int m_xmin [NUM_SEG];
  int m_xmax [NUM_SEG];

  function automatic void chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("x",         int'(bus.x),         mx);
      chk("y",         int'(bus.y),         my);
      chk("busy",      int'(bus.busy),      int'(e_busy));
      chk("draw_bg",   int'(bus.draw_bg),   int'(e_bg));
      chk("draw_char", int'(bus.draw_char), int'(e_char));
      chk("move_ok",   int'(bus.move_ok),   int'(e_ok));
      chk("move_rej",  int'(bus.move_rej),  int'(e_rej));
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    mx = INIT_X;
    my = INIT_Y;
    for (int i = 0; i < NUM_SEG; i++) m_en[i] = 1'b0;
  endtask

  // Advance one clock; expectations for the new cycle are set by the caller afterwards
  task automatic nxt();
    @(posedge clock);
    #1;
    nbusy += int'(bus.busy);
    e_busy = 0; e_bg = 0; e_char = 0; e_ok = 0; e_rej = 0;
    bus.ld_dir = 0; bus.move = 0; bus.set_pos = 0; bus.seg_we = 0;
    bus.done_bg = 0; bus.done_char = 0;
  endtask

  task automatic wr_seg(input int idx, input bit en, input bit kind, input int c,
                        input int xmin, input int xmax);
    logic signed [C_W-1:0] cv;
    logic [X_W-1:0] xl, xh;
    logic [IDX_W-1:0] iv;
    cv = c[C_W-1:0];
    xl = xmin[X_W-1:0];
    xh = xmax[X_W-1:0];
    iv = idx[IDX_W-1:0];
    bus.seg_we = 1; bus.seg_idx = iv; bus.seg_en = en; bus.seg_kind = kind;
    bus.seg_c = cv; bus.seg_xmin = xl; bus.seg_xmax = xh;
    m_en[iv] = en; m_kind[iv] = kind; m_c[iv] = int'(cv);
    m_xmin[iv] = int'(xl); m_xmax[iv] = int'(xh);
    nxt();
  endtask

  task automatic set_p(input int px, input int py);
    bus.set_pos = 1;
    bus.pos_x = px[X_W-1:0];
    bus.pos_y = py[Y_W-1:0];
    nxt();
    mx = px;
    my = py;
  endtask

  function automatic int find_hit(input int tx, input int ty);
    for (int i = 0; i < NUM_SEG; i++) begin
      if (m_en[i] && m_xmin[i] <= tx && tx <= m_xmax[i] &&
          ((m_kind[i] ? (ty - tx) : (tx + ty)) == m_c[i]))
        return i;
    end
    return -1;
  endfunction

  // Arm, request, and follow one move to its return to IDLE
  task automatic run_move(input int d, input bit relatch, input bit scan_wr, input bit spur,
                          input bit rst_mid, input int dly1, input int dly2,
                          output int h, output bit acc);
    logic [1:0] dv;
    int tx, ty, last;
    dv = d[1:0];
    h = -1;
    acc = 0;
    nbusy = 0;
    bus.ld_dir = 1;
    bus.dir = relatch ? ~dv : dv;
    nxt();
    if (relatch) begin
      bus.ld_dir = 1; bus.dir = dv;
      bus.set_pos = 1; bus.pos_x = X_W'($urandom); bus.pos_y = Y_W'($urandom);
    end
    bus.move = 1;
    nxt();
    e_busy = 1;
    tx = mx + (dv[0] ? -STEP : STEP);
    ty = my + (dv[1] ? -STEP : STEP);
    if (tx <= 0 || tx > X_MAX || ty <= 0 || ty > Y_MAX) begin
      nxt();
      e_rej = 1;
      return;
    end
    h = find_hit(tx, ty);
    last = (h < 0) ? NUM_SEG - 1 : h;
    for (int i = 0; i <= last; i++) begin
      nxt();
      e_busy = 1;
      if (scan_wr && i == 0) begin
        bus.seg_we = 1; bus.seg_idx = last[IDX_W-1:0]; bus.seg_en = 0;
      end
    end
    if (h < 0) begin
      nxt();
      e_rej = 1;
      return;
    end
    nxt();
    e_busy = 1; e_bg = 1;
    if (spur) bus.done_bg = 1;
    for (int j = 0; j < dly1; j++) begin
      nxt();
      e_busy = 1;
      if (rst_mid) begin
        resetn = 0;
        nxt();
        model_reset();
        resetn = 1;
        bus.done_bg = 1;
        nxt();
        return;
      end
      if (j == dly1 - 1) bus.done_bg = 1;
      if (spur && j == 0) bus.done_char = 1;
    end
    nxt();
    e_busy = 1;
    nxt();
    e_busy = 1; e_char = 1;
    mx = tx; my = ty;
    if (spur) bus.done_char = 1;
    for (int j = 0; j < dly2; j++) begin
      nxt();
      e_busy = 1;
      if (j == dly2 - 1) bus.done_char = 1;
    end
    nxt();
    e_ok = 1;
    acc = 1;
  endtask

  initial begin
    int h;
    bit acc;
    int px, py, d, tx, ty, c, xl, xh, kind;
    resetn = 0;
    bus.ld_dir = 0; bus.dir = 0; bus.move = 0; bus.set_pos = 0;
    bus.pos_x = 0; bus.pos_y = 0; bus.seg_we = 0; bus.seg_idx = 0;
    bus.seg_en = 0; bus.seg_kind = 0; bus.seg_c = 0; bus.seg_xmin = 0; bus.seg_xmax = 0;
    bus.done_bg = 0; bus.done_char = 0;
    model_reset();
    e_busy = 0; e_bg = 0; e_char = 0; e_ok = 0; e_rej = 0;
    nbusy = 0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1;
    chk_en = 1;
    nxt();

    // Empty table: full scan then reject
    run_move(0, 0, 0, 0, 0, 1, 1, h, acc);
    chk("t1_busy_cycles", nbusy, 9);
    chk("t1_accepted", int'(acc), 0);
    chk("t1_x", int'(bus.x), 1);
    nxt();

    wr_seg(0, 1, 0, 222, 96, 122);
    set_p(100, 122);
    run_move(2, 0, 0, 0, 0, 5, 2, h, acc);
    chk("t2_hit_idx", h, 0);
    chk("t2_x", int'(bus.x), 101);
    chk("t2_y", int'(bus.y), 121);
    chk("t2_accepted", int'(acc), 1);
    nxt();

    set_p(122, 100);
    run_move(2, 0, 0, 0, 0, 1, 1, h, acc);
    chk("t3_accepted", int'(acc), 0);
    chk("t3_x", int'(bus.x), 122);
    chk("t3_busy_cycles", nbusy, 9);
    nxt();

    set_p(1, 50);
    run_move(1, 0, 0, 0, 0, 1, 1, h, acc);
    chk("t4a_busy_cycles", nbusy, 1);
    nxt();
    set_p(319, 50);
    run_move(0, 0, 0, 0, 0, 1, 1, h, acc);
    chk("t4b_busy_cycles", nbusy, 1);
    nxt();

    // set_pos wins over ld_dir, so the following move must be ignored
    bus.set_pos = 1; bus.ld_dir = 1; bus.dir = 0; bus.pos_x = 40; bus.pos_y = 40;
    nxt();
    mx = 40; my = 40;
    bus.move = 1;
    nxt();
    nxt();
    chk("prio_busy", int'(bus.busy), 0);

    wr_seg(0, 0, 0, 0, 0, 0);
    wr_seg(7, 1, 1, 96, 127, 181);
    set_p(130, 226);
    run_move(0, 0, 1, 0, 0, 3, 3, h, acc);
    chk("t5_hit_idx", h, 7);
    chk("t5_x", int'(bus.x), 131);
    chk("t5_y", int'(bus.y), 227);
    nxt();

    wr_seg(0, 1, 0, 222, 96, 122);
    set_p(100, 122);
    run_move(2, 0, 0, 0, 1, 4, 1, h, acc);
    chk("t6_x_after_rst", int'(bus.x), 1);
    chk("t6_y_after_rst", int'(bus.y), 16);
    nxt();
    set_p(100, 122);
    run_move(2, 0, 0, 0, 0, 1, 1, h, acc);
    chk("t6_table_cleared", int'(acc), 0);
    nxt();

    for (int n = 0; n < 60; n++) begin
      px = $urandom_range(0, X_MAX);
      py = $urandom_range(0, Y_MAX);
      if ($urandom_range(0, 7) == 0) px = ($urandom_range(0, 1) == 0) ? 0 : X_MAX;
      if ($urandom_range(0, 7) == 0) py = ($urandom_range(0, 1) == 0) ? 1 : Y_MAX;
      d = $urandom_range(0, 3);
      tx = px + ((d % 2) ? -STEP : STEP);
      ty = py + ((d / 2) ? -STEP : STEP);
      if ($urandom_range(0, 9) < 7) begin
        kind = $urandom_range(0, 1);
        c = kind ? (ty - tx) : (tx + ty);
        if ($urandom_range(0, 9) < 2) c = c + (($urandom_range(0, 1) == 0) ? 1 : -1);
        xl = tx - $urandom_range(0, 5);
        xh = tx + $urandom_range(0, 5);
        if ($urandom_range(0, 9) == 0) begin xl = tx + 1; xh = tx - 1; end
        if (xl < 0) xl = 0;
        if (xh < 0) xh = 0;
        if (xl > 511) xl = 511;
        if (xh > 511) xh = 511;
        wr_seg($urandom_range(0, NUM_SEG - 1), ($urandom_range(0, 7) != 0), kind[0], c, xl, xh);
      end
      set_p(px, py);
      run_move(d, $urandom_range(0, 1), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
               0, $urandom_range(1, 6), $urandom_range(1, 6), h, acc);
      nxt();
      if ($urandom_range(0, 5) == 0) begin
        bus.move = 1;
        nxt();
      end
    end

    nxt();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
